// File: rtl/regfile_pkg.sv
// Shared defaults and write-port arbitration helper for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  // Helper buses are sized for the largest supported configuration; callers zero-extend.
  localparam int MAX_WR     = 16;
  localparam int MAX_ADDR_W = 16;
  localparam int WIDX_W     = $clog2(MAX_WR);

  typedef struct packed {
    logic              hit;
    logic [WIDX_W-1:0] idx;
  } wr_win_t;

  // Highest-indexed enabled write port targeting addr wins.
  function automatic wr_win_t wr_winner(
    input logic [MAX_ADDR_W-1:0]        addr,
    input logic [MAX_WR-1:0]            wr_en,
    input logic [MAX_WR*MAX_ADDR_W-1:0] wr_addr
  );
    wr_win_t r;
    r = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
        r.hit = 1'b1;
        r.idx = WIDX_W'(w);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Next-value selection for one read port: applies write-first bypass, scoreboard update
// and the hardwired zero register to the stored word and busy bit.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        stored,
  input  logic                     stored_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DATA_W-1:0]        nxt_data,
  output logic                     nxt_busy
);

  logic [MAX_WR-1:0]            en_ext;
  logic [MAX_WR*MAX_ADDR_W-1:0] addr_ext;
  wr_win_t                      win;

  always_comb begin
    en_ext   = '0;
    addr_ext = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      en_ext[w] = wr_en[w];
      addr_ext[w*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wr_addr[w*ADDR_W +: ADDR_W]);
    end
  end

  assign win = wr_winner(MAX_ADDR_W'(addr), en_ext, addr_ext);

  always_comb begin
    nxt_data = stored;
    nxt_busy = stored_busy;
    if (BYPASS != 0) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (win.hit && (win.idx == WIDX_W'(w))) nxt_data = wr_data[w*DATA_W +: DATA_W];
      end
      // Reserve is applied after the writeback clear: a new producer owns the entry.
      if (win.hit) nxt_busy = 1'b0;
      if (rsv_en && (rsv_addr == addr)) nxt_busy = 1'b1;
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      nxt_data = '0;
      nxt_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with registered reads, write-first bypass option,
// optional zero register and a per-entry busy scoreboard for hazard detection.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DATA_W-1:0] rdq [NUM_RD];
  logic [NUM_RD-1:0] rbq;
  logic [DATA_W-1:0] nxt_data [NUM_RD];
  logic              nxt_busy [NUM_RD];

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Storage and scoreboard: later write ports overwrite earlier ones in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && writable(wr_addr[w*ADDR_W +: ADDR_W])) begin
          mem[wr_addr[w*ADDR_W +: ADDR_W]]  <= wr_data[w*DATA_W +: DATA_W];
          busy[wr_addr[w*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (rsv_en && writable(rsv_addr)) busy[rsv_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[p*ADDR_W +: ADDR_W];

    regfile_bypass_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_mux (
      .addr        (ra),
      .stored      (mem[ra]),
      .stored_busy (busy[ra]),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rsv_en      (rsv_en),
      .rsv_addr    (rsv_addr),
      .nxt_data    (nxt_data[p]),
      .nxt_busy    (nxt_busy[p])
    );
  end

  // Read output registers: a disabled port holds its last result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_RD; p++) rdq[p] <= '0;
      rbq <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rdq[p] <= nxt_data[p];
          rbq[p] <= nxt_busy[p];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) rd_data[p*DATA_W +: DATA_W] = rdq[p];
  end

  assign rd_busy = rbq;

endmodule
